// File: rtl/qpu_ifu_pkg.sv
// Shared types and constants for the QPU instruction-fetch stage.
// Entry widths follow `QPU_PC_SIZE / `QPU_INSTR_SIZE (defaulted here when not supplied).
`ifndef QPU_PC_SIZE
`define QPU_PC_SIZE 32
`endif
`ifndef QPU_INSTR_SIZE
`define QPU_INSTR_SIZE 32
`endif

package qpu_ifu_pkg;

  localparam int IFU_PC_W    = `QPU_PC_SIZE;
  localparam int IFU_INSTR_W = `QPU_INSTR_SIZE;
  localparam int IRQ_DEPTH   = 2;
  localparam int IR_ENTRY_W  = IFU_INSTR_W + IFU_PC_W + 1;

  localparam logic [6:0] QPU_OPC_BRANCH = 7'b1100011;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } ifu_state_e;

  typedef struct packed {
    logic [IFU_INSTR_W-1:0] instr;
    logic [IFU_PC_W-1:0]    pc;
    logic                   prdt_taken;
  } ir_entry_t;

  // B-type immediate, bit 0 always zero; sign lives in bit 12.
  function automatic logic signed [12:0] branch_imm(input logic [31:0] instr);
    return {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/qpu_ifu_irq.sv
// Two-entry in-order IR queue with valid/ready read side and synchronous clear.
// When empty the read data holds the most recently popped entry.
module qpu_ifu_irq
  import qpu_ifu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [IR_ENTRY_W-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [IR_ENTRY_W-1:0] rd_data,
  output logic [1:0]            count
);

  ir_entry_t mem [IRQ_DEPTH];
  ir_entry_t last;
  logic      wptr;
  logic      rptr;
  logic      pop;
  logic      push;

  assign rd_valid = (count != 2'd0);
  assign pop      = rd_valid & rd_ready;
  assign push     = wr_en & ~clr;
  assign rd_data  = rd_valid ? mem[rptr] : last;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      last  <= '0;
    end else begin
      if (pop) last <= mem[rptr];
      if (clr) begin
        count <= 2'd0;
        wptr  <= 1'b0;
        rptr  <= 1'b0;
      end else begin
        count <= count + {1'b0, push} - {1'b0, pop};
        if (push) wptr <= ~wptr;
        if (pop)  rptr <= ~rptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/qpu_ifu_fetch.sv
// QPU instruction fetch / IR stage: sequential fetch, IR queue, flush and WFI halt.
// Define QPU_IFU_STATIC_BPU_EN for static backward-taken branch prediction. PC_SIZE must match `QPU_PC_SIZE.
module qpu_ifu_fetch
  import qpu_ifu_pkg::*;
#(
  parameter int                 PC_SIZE    = `QPU_PC_SIZE,
  parameter int                 INSTR_SIZE = `QPU_INSTR_SIZE,
  parameter logic [PC_SIZE-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ifu_req_valid,
  output logic [PC_SIZE-1:0]    ifu_req_addr,
  input  logic                  ifu_rsp_valid,
  input  logic [INSTR_SIZE-1:0] ifu_rsp_instr,
  output logic                  ifu_o_valid,
  input  logic                  ifu_o_ready,
  output logic [INSTR_SIZE-1:0] ifu_o_instr,
  output logic [PC_SIZE-1:0]    ifu_o_pc,
  output logic                  ifu_o_prdt_taken,
  input  logic                  pipe_flush_req,
  input  logic [PC_SIZE-1:0]    pipe_flush_pc,
  input  logic                  halt_req,
  output logic                  halt_ack
);

  ifu_state_e         state;
  ifu_state_e         state_nxt;
  logic               outstanding;
  logic               flush_pend;
  logic [PC_SIZE-1:0] pc_q;
  logic [PC_SIZE-1:0] rsp_pc;
  logic [PC_SIZE-1:0] next_pc;
  logic               rsp_ok;
  logic               prdt_taken;
  logic               pop;
  logic               clr;
  logic [1:0]         q_count;
  logic [2:0]         occ;
  ir_entry_t          wr_entry;
  ir_entry_t          rd_entry;

  // A response counts only if we asked for it and no redirect is squashing it.
  assign rsp_ok = ifu_rsp_valid & outstanding & ~pipe_flush_req & ~flush_pend;

`ifdef QPU_IFU_STATIC_BPU_EN
  logic signed [12:0] bimm;
  assign bimm       = branch_imm(ifu_rsp_instr);
  assign prdt_taken = (ifu_rsp_instr[6:0] == QPU_OPC_BRANCH) & bimm[12];
  assign next_pc    = prdt_taken ? rsp_pc + PC_SIZE'(bimm) : rsp_pc + PC_SIZE'(4);
`else
  assign prdt_taken = 1'b0;
  assign next_pc    = rsp_pc + PC_SIZE'(4);
`endif

  assign ifu_req_addr = rsp_ok ? next_pc : pc_q;
  assign pop          = ifu_o_valid & ifu_o_ready;
  assign occ          = 3'(q_count) + 3'(outstanding) - 3'(pop);
  assign clr          = pipe_flush_req & (state == FETCH);

  always_comb begin
    state_nxt     = state;
    halt_ack      = 1'b0;
    ifu_req_valid = 1'b0;
    case (state)
      FETCH: begin
        ifu_req_valid = ~rst & ~halt_req & ~flush_pend & ~pipe_flush_req &
                        (occ < 3'(IRQ_DEPTH));
        if (halt_req & ~outstanding) state_nxt = HALTED;
      end
      HALTED: begin
        halt_ack = 1'b1;
        if (~halt_req) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Request stage -> response stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      outstanding <= 1'b0;
      flush_pend  <= 1'b0;
      pc_q        <= RESET_PC;
    end else begin
      state       <= state_nxt;
      outstanding <= ifu_req_valid;
      flush_pend  <= pipe_flush_req & ifu_req_valid;
      if (pipe_flush_req)
        pc_q <= pipe_flush_pc;
      else if (rsp_ok)
        pc_q <= next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (ifu_req_valid) rsp_pc <= ifu_req_addr;
  end

  // Response stage -> IR queue
  assign wr_entry = '{instr: ifu_rsp_instr, pc: rsp_pc, prdt_taken: prdt_taken};

  qpu_ifu_irq u_irq (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .wr_en    (rsp_ok),
    .wr_data  (wr_entry),
    .rd_valid (ifu_o_valid),
    .rd_ready (ifu_o_ready),
    .rd_data  (rd_entry),
    .count    (q_count)
  );

  assign ifu_o_instr      = rd_entry.instr;
  assign ifu_o_pc         = rd_entry.pc;
  assign ifu_o_prdt_taken = rd_entry.prdt_taken;

endmodule

// File: tb/tb_qpu_ifu_fetch.sv
// Directed bench for qpu_ifu_fetch: word-addressed memory model feeding a scoreboard of
// expected IR entries, with an independent next-address model for every request.
`timescale 1ns/1ps
module tb_qpu_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid = 1'b0;
  logic [31:0] ifu_rsp_instr = 32'h0;
  logic        ifu_o_valid;
  logic        ifu_o_ready;
  logic [31:0] ifu_o_instr;
  logic [31:0] ifu_o_pc;
  logic        ifu_o_prdt_taken;
  logic        pipe_flush_req;
  logic [31:0] pipe_flush_pc;
  logic        halt_req;
  logic        halt_ack;

  always #5 clk = ~clk;

  qpu_ifu_fetch #(.RESET_PC(32'h0)) dut (
    .clk              (clk),
    .rst              (rst),
    .ifu_req_valid    (ifu_req_valid),
    .ifu_req_addr     (ifu_req_addr),
    .ifu_rsp_valid    (ifu_rsp_valid),
    .ifu_rsp_instr    (ifu_rsp_instr),
    .ifu_o_valid      (ifu_o_valid),
    .ifu_o_ready      (ifu_o_ready),
    .ifu_o_instr      (ifu_o_instr),
    .ifu_o_pc         (ifu_o_pc),
    .ifu_o_prdt_taken (ifu_o_prdt_taken),
    .pipe_flush_req   (pipe_flush_req),
    .pipe_flush_pc    (pipe_flush_pc),
    .halt_req         (halt_req),
    .halt_ack         (halt_ack)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        taken;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [64];
  int          mem_off [64];
  bit          mem_br [64];
  exp_t        sb [$];
  logic [31:0] exp_fetch = 32'h0;
  int          cyc = 0;
  int          req_count = 0;
  int          pops = 0;
  bit          seen_req = 1'b0;
  bit          seen_vld = 1'b0;
  int          first_req_cyc = 0;
  int          first_vld_cyc = 0;
  bit          have_last = 1'b0;
  logic [31:0] last_req = 32'h0;
  bit          got_after10 = 1'b0;
  logic [31:0] first_after10 = 32'h0;
  logic [31:0] last_after10 = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  function automatic logic [31:0] enc_addi(input int i);
    return {12'(i), 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  function automatic logic [31:0] enc_br(input int off);
    logic [12:0] b;
    b = 13'(off);
    return {b[12], b[10:5], 5'd2, 5'd1, 3'b000, b[4:1], b[11], 7'h63};
  endfunction

  task automatic set_addi(input int idx);
    mem[idx] = enc_addi(idx); mem_off[idx] = 0; mem_br[idx] = 1'b0;
  endtask

  task automatic set_br(input int idx, input int off);
    mem[idx] = enc_br(off); mem_off[idx] = off; mem_br[idx] = 1'b1;
  endtask

  function automatic logic exp_taken(input int idx);
`ifdef QPU_IFU_STATIC_BPU_EN
    return mem_br[idx] && (mem_off[idx] < 0);
`else
    return 1'b0;
`endif
  endfunction

  // Memory: samples the request at the edge, answers one cycle later.
  always @(posedge clk) begin : mem_model
    logic        rv;
    logic [31:0] ra;
    logic [31:0] rdata;
    exp_t        e;
    int          ei;
    rv = ifu_req_valid;
    ra = ifu_req_addr;
    if (rv && !seen_req) begin seen_req = 1'b1; first_req_cyc = cyc; end
    cyc++;
    rdata = mem[ra[7:2]];
    e = '{pc: 32'h0, instr: 32'h0, taken: 1'b0};
    if (rv) begin
      req_count++;
      chk("req_addr", ra, exp_fetch);
      if (have_last && last_req == 32'h10) begin
        if (!got_after10) begin first_after10 = ra; got_after10 = 1'b1; end
        last_after10 = ra;
      end
      last_req = ra; have_last = 1'b1;
      ei = int'(exp_fetch[7:2]);
      e.pc = exp_fetch; e.instr = mem[ei]; e.taken = exp_taken(ei);
      exp_fetch = e.taken ? exp_fetch + 32'(mem_off[ei]) : exp_fetch + 32'd4;
    end
    #1;
    ifu_rsp_valid = rv;
    ifu_rsp_instr = rv ? rdata : 32'h0;
    if (rv) sb.push_back(e);
  end

  // Decoder side: every valid entry is compared with the scoreboard head.
  always @(negedge clk) begin : monitor
    if (!rst && !pipe_flush_req && ifu_o_valid) begin
      if (!seen_vld) begin seen_vld = 1'b1; first_vld_cyc = cyc; end
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL o_unexpected: got pc %h expected no entry", ifu_o_pc);
      end
      if (sb.size() != 0) begin
        chk("o_pc", ifu_o_pc, sb[0].pc);
        chk("o_instr", ifu_o_instr, sb[0].instr);
        chk("o_prdt_taken", 32'(ifu_o_prdt_taken), 32'(sb[0].taken));
        if (ifu_o_ready) begin
          void'(sb.pop_front());
          pops++;
        end
      end
    end
  end

  task automatic do_flush(input logic [31:0] fpc);
    @(posedge clk); #1;
    pipe_flush_req = 1'b1; pipe_flush_pc = fpc; ifu_o_ready = 1'b0;
    #1;
    sb.delete();
    exp_fetch = fpc;
    @(negedge clk);
    chk("flush_no_req", 32'(ifu_req_valid), 32'd0);
    @(posedge clk); #1;
    pipe_flush_req = 1'b0; ifu_o_ready = 1'b1;
    @(negedge clk);
    chk("flush_q_empty", 32'(ifu_o_valid), 32'd0);
    chk("flush_req_valid", 32'(ifu_req_valid), 32'd1);
    chk("flush_req_addr", ifu_req_addr, fpc);
    for (int i = 0; i < 5 && !ifu_o_valid; i++) @(negedge clk);
    chk("flush_first_valid", 32'(ifu_o_valid), 32'd1);
    chk("flush_first_pc", ifu_o_pc, fpc);
  endtask

  initial begin
    int p0;
    int rc;
    for (int i = 0; i < 64; i++) set_addi(i);
    set_br(4, -8);
    rst = 1'b1; ifu_o_ready = 1'b0; pipe_flush_req = 1'b0;
    pipe_flush_pc = 32'h0; halt_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(ifu_req_valid), 32'd0);
    chk("rst_req_addr", ifu_req_addr, 32'h0);
    chk("rst_o_valid", 32'(ifu_o_valid), 32'd0);
    chk("rst_o_instr", ifu_o_instr, 32'h0);
    chk("rst_o_pc", ifu_o_pc, 32'h0);
    chk("rst_o_prdt", 32'(ifu_o_prdt_taken), 32'd0);
    chk("rst_halt_ack", 32'(halt_ack), 32'd0);

    // Streaming from reset, backward branch at 0x10.
    @(posedge clk); #1;
    rst = 1'b0; ifu_o_ready = 1'b1;
    repeat (14) @(posedge clk);
    chk("first_valid_latency", 32'(first_vld_cyc - first_req_cyc), 32'd2);
    p0 = pops;
    repeat (8) @(posedge clk);
    chk("throughput", 32'(pops - p0), 32'd8);
    chk("after10_seen", 32'(got_after10), 32'd1);
`ifdef QPU_IFU_STATIC_BPU_EN
    chk("after10_neg_branch", first_after10, 32'h08);
`else
    chk("after10_neg_branch", first_after10, 32'h14);
`endif

    // Forward branch at 0x10 is predicted not taken.
    #1 set_br(4, 8);
    repeat (10) @(posedge clk);
    chk("after10_pos_branch", last_after10, 32'h14);

    // Decoder stall: queue fills, requests stop, head stays put.
    #1 ifu_o_ready = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("stall_no_req", 32'(ifu_req_valid), 32'd0);
    chk("stall_q_depth", 32'(sb.size()), 32'd2);
    chk("stall_o_valid", 32'(ifu_o_valid), 32'd1);
    @(posedge clk); #1 ifu_o_ready = 1'b1;
    repeat (6) @(posedge clk);

    // Flush while streaming (response in flight), then with a full queue.
    do_flush(32'h40);
    repeat (4) @(posedge clk);
    #1 ifu_o_ready = 1'b0;
    repeat (4) @(posedge clk);
    do_flush(32'h80);
    repeat (4) @(posedge clk);

    // Reset taken mid-stream discards queue and in-flight response.
    #1 rst = 1'b1;
    #1 sb.delete(); exp_fetch = 32'h0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_o_valid", 32'(ifu_o_valid), 32'd0);
    chk("midrst_o_pc", ifu_o_pc, 32'h0);
    chk("midrst_req_valid", 32'(ifu_req_valid), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk);

    // WFI halt with a request outstanding, then resume.
    #1 halt_req = 1'b1;
    rc = req_count;
    @(negedge clk);
    chk("halt_no_req", 32'(ifu_req_valid), 32'd0);
    for (int i = 0; i < 5 && !halt_ack; i++) @(negedge clk);
    chk("halt_ack", 32'(halt_ack), 32'd1);
    repeat (3) @(negedge clk);
    chk("halt_req_count", 32'(req_count), 32'(rc));
    chk("halt_q_drained", 32'(sb.size()), 32'd0);
    @(posedge clk); #1 halt_req = 1'b0;
    for (int i = 0; i < 5 && !ifu_req_valid; i++) @(negedge clk);
    chk("resume_req_valid", 32'(ifu_req_valid), 32'd1);
    chk("resume_req_addr", ifu_req_addr, exp_fetch);
    chk("resume_halt_ack", 32'(halt_ack), 32'd0);
    repeat (5) @(posedge clk);

    // Quiesce and confirm nothing was lost.
    #1 halt_req = 1'b1;
    for (int i = 0; i < 6 && !halt_ack; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("end_halt_ack", 32'(halt_ack), 32'd1);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);
    chk("end_o_valid", 32'(ifu_o_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
